// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// radix-2 Booth pair decode.
package mult_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } mult_state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // Pair is {q0, q-1}; 00 and 11 both leave the accumulator alone.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth radix-2 iteration: decode the low pair of P, add/sub M into the
// upper accumulator (modulo 2^(WIDTH+1)), then arithmetic-shift all of P right.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int PW   = 2 * (WIDTH + 1) + 1
) (
  input  logic [PW-1:0]  p,
  input  logic [WIDTH:0] m,
  output logic [PW-1:0]  p_next
);

  logic [WIDTH:0] acc;
  logic [WIDTH:0] acc_sum;
  logic [PW-1:0]  p_sum;

  assign acc = p[PW-1 -: WIDTH + 1];

  always_comb begin
    acc_sum = acc;
    case (booth_decode(p[1:0]))
      BOOTH_ADD: acc_sum = acc + m;
      BOOTH_SUB: acc_sum = acc - m;
      default:   acc_sum = acc;
    endcase
    p_sum  = {acc_sum, p[WIDTH+1:0]};
    p_next = {p_sum[PW-1], p_sum[PW-1:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth radix-2 multiplier, signed or unsigned per operation,
// with start/busy/done handshake and synchronous abort.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 sysClk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * (WIDTH + 1) + 1;

  mult_state_t      state;
  logic [WIDTH:0]   m_reg;
  logic [PW-1:0]    p_reg;
  logic [PW-1:0]    p_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;

  // One extra bit lets the same signed Booth engine handle unsigned operands.
  always_comb begin
    a_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    b_ext = {signed_mode & multiplier[WIDTH-1], multiplier};
  end

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .m      (m_reg),
    .p_next (p_next)
  );

  always_ff @(posedge sysClk) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      m_reg   <= '0;
      p_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a_ext;
            p_reg <= {{(WIDTH + 1){1'b0}}, b_ext, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            p_reg <= p_next;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH)) begin
              product <= p_next[2*WIDTH:1];
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential Booth radix-2 multiplier with its control FSM and datapath in one block. It is the next-generation replacement for the fixed 32-bit `multu` control/datapath pair. It adds a width parameter, signed and unsigned modes selected per operation, a single-cycle combined add/sub+shift step, a start/busy/done handshake and a synchronous abort. It sits beside the ALU and is started by the execute-stage controller.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits (≥ 4).
- `CNT_W`, `$clog2(WIDTH+2)`, iteration counter width (derived; do not override).

Ports:
- `sysClk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `abort`  in  1  synchronous cancel of an operation in progress.
- `multiplicand`  in  WIDTH  operand A; sampled with `start`.
- `multiplier`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  2*WIDTH  result; held until the next accepted `start`.

## Operation
- Operand extension: both operands are extended to WIDTH+1 bits. Extension is sign extension when `signed_mode`=1 and zero extension otherwise. This lets one Booth engine serve both modes.
- Internal registers:
  - `M` (WIDTH+1): extended multiplicand.
  - `P` (2*(WIDTH+1)+1): holds {upper accumulator, extended multiplier, q₋₁}.
  - `cnt` (CNT_W).
  - `state`.
- States and transitions:
  - IDLE to RUN on `start`=1.
  - RUN to IDLE after iteration WIDTH+1 completes, or on `abort`.
  - There is no separate DONE state; `done` is a registered pulse.
- Load (IDLE, `start`=1):
  - `M` ← ext(A).
  - `P` ← {0, ext(B), 1'b0}.
  - `cnt` ← 0.
  - `busy` ← 1.
- Iteration (RUN), selected by the pair {P[1], P[0]}:
  - 01: add `M` to the upper WIDTH+1 bits of `P`.
  - 10: subtract `M` from the upper WIDTH+1 bits of `P`.
  - 00 or 11: no change.
  - After the add/sub, arithmetic right shift of the whole of `P` by 1, in the same cycle.
  - Add/sub is modulo 2^(WIDTH+1); the carry is discarded.
  - `cnt` increments.
- Completion: when `cnt` = WIDTH (the last iteration is being performed):
  - `product` ← low 2*WIDTH bits of the shifted result, excluding q₋₁.
  - `done` ← 1 for one cycle.
  - `busy` ← 0.
  - state ← IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` in the `done` cycle is accepted, so back-to-back operations are allowed.
- `abort` in RUN:
  - Next edge: state ← IDLE, `busy` ← 0, no `done`.
  - `product` keeps its previous value.
  - `abort` in IDLE has no effect.
  - `abort` takes priority over completion in the same cycle.
- Reset (`reset_n`=0 at an edge), in any state including mid-operation:
  - state IDLE; `busy`=0, `done`=0, `product`=0.
  - `cnt`=0, `M`=0, `P`=0.

## Timing
- `start` is sampled at edge E0. Iterations occur at edges E1 … E(WIDTH+1).
- `done` is high and `product` valid in the cycle following E(WIDTH+1).
- Latency from the sampling edge to `done`: WIDTH+1 cycles. Example: 33 cycles for WIDTH=32.
- `busy` is high from after E0 until E(WIDTH+1). It is low in the `done` cycle.
- Throughput: one result per WIDTH+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN}.
  - Booth pair encodings `BOOTH_NOP`, `BOOTH_ADD`, `BOOTH_SUB`.
- One natural sub-module, `booth_step`: combinational function of `P` and `M` that returns the next `P` (decode, add/sub, arithmetic shift). The FSM, counter and registers stay in `booth_mult_seq`.

## Test plan
- WIDTH=32, signed, A=-7 (0xFFFFFFF9), B=3 → `done` 33 cycles after `start`; `product` = 0xFFFFFFFF_FFFFFFEB.
- WIDTH=32, unsigned, A=B=0xFFFFFFFF → `product` = 0xFFFFFFFE_00000001.
- WIDTH=32, signed, A=B=0x80000000 → `product` = 0x40000000_00000000. Same operands unsigned → 0x40000000_00000000 as well. Also check A=0x80000000, B=1 signed → 0xFFFFFFFF_80000000.
- WIDTH=8, exhaustive sweep of all 65536 operand pairs in both modes → every `product` matches a reference model. `done` arrives exactly 9 cycles after each `start`, and the sweep runs back-to-back with `start` asserted in each `done` cycle.
- WIDTH=32 abort and ignored start:
  - `start` (5×6), then `abort` at cycle 10 → `busy` falls next edge, no `done`, `product` keeps the previous result.
  - A `start` issued mid-RUN is ignored: `done` pulses once, for the first operation only.
- Reset mid-op: `reset_n`=0 at cycle 12 of an operation → next cycle `busy`=0, `done`=0, `product`=0. A fresh `start` afterwards completes correctly.
